// File: rtl/pico_mips_core_if.sv
// Core-side bundle: program fetch (pc/instr), switch input handshake and LED/status outputs.
interface pico_mips_core_if #(
    parameter int DW     = 8,
    parameter int NREG   = 8,
    parameter int PDEPTH = 32
);
    localparam int RW = $clog2(NREG);
    localparam int PW = $clog2(PDEPTH);
    localparam int IW = 3 + 2 * RW + DW;

    logic [IW-1:0] instr;
    logic [PW-1:0] pc;
    logic [DW-1:0] sw_data;
    logic          sw_go;
    logic [DW-1:0] led;
    logic          busy;
    logic          halted;

    modport master (
        input  instr, sw_data, sw_go,
        output pc, led, busy, halted
    );

    modport slave (
        output instr, sw_data, sw_go,
        input  pc, led, busy, halted
    );
endinterface

// File: rtl/pico_mips_core.sv
// Multi-cycle accumulator core: single-cycle ALU/branch ops, DW-cycle shift-add MUL (DW+1 total),
// IN stalls pc until one full press/release of the synchronised button; HALT is terminal.
module pico_mips_core #(
    parameter int DW     = 8,
    parameter int NREG   = 8,
    parameter int PDEPTH = 32
) (
    input logic              clk_i,
    input logic              rst_i,
    pico_mips_core_if.master bus
);
    localparam int RW = $clog2(NREG);
    localparam int PW = $clog2(PDEPTH);
    localparam int IW = 3 + 2 * RW + DW;
    localparam int CW = $clog2(DW);

    localparam logic [2:0] OP_LDI  = 3'd0;
    localparam logic [2:0] OP_ADD  = 3'd1;
    localparam logic [2:0] OP_ADDI = 3'd2;
    localparam logic [2:0] OP_MUL  = 3'd3;
    localparam logic [2:0] OP_IN   = 3'd4;
    localparam logic [2:0] OP_OUT  = 3'd5;
    localparam logic [2:0] OP_BNZ  = 3'd6;

    typedef enum logic [2:0] {
        S_EXEC, S_MUL, S_WAIT_PRESS, S_WAIT_RELEASE, S_HALT
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   pc_q, pc_d;
    logic [DW-1:0]   led_q, led_d;
    logic [DW-1:0]   regs_q [NREG];
    logic [2*DW-1:0] mcand_q, mcand_d, acc_q, acc_d;
    logic [DW-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            sync1_q, sync2_q, sw_go_s;

    logic [2:0]      op;
    logic [RW-1:0]   rd, rs;
    logic [DW-1:0]   imm, rd_val, rs_val;
    logic [PW-1:0]   pc_inc, br_tgt, br_dst;
    logic [2*DW-1:0] acc_step;
    logic [DW-1:0]   mul_res;
    logic            mul_last;
    logic            wr_en;
    logic [DW-1:0]   wr_dat;
    logic            busy, halted;

    assign op       = bus.instr[IW-1 -: 3];
    assign rd       = bus.instr[DW+RW +: RW];
    assign rs       = bus.instr[DW +: RW];
    assign imm      = bus.instr[DW-1:0];
    assign rd_val   = regs_q[rd];
    assign rs_val   = regs_q[rs];
    assign sw_go_s  = sync2_q;
    assign pc_inc   = (pc_q == PW'(PDEPTH - 1)) ? '0 : pc_q + PW'(1);
    assign br_dst   = ({1'b0, br_tgt} >= (PW+1)'(PDEPTH)) ? '0 : br_tgt;
    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign mul_res  = imm[0] ? acc_step[2*DW-1:DW] : acc_step[DW-1:0];
    assign mul_last = (cnt_q == CW'(DW - 1));

    // Branch target is the low PW bits of imm, zero-filled if imm is narrower.
    always_comb begin
        br_tgt = '0;
        for (int b = 0; b < PW; b++) begin
            if (b < DW) br_tgt[b] = imm[b];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= S_EXEC;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_EXEC: begin
                case (op)
                    OP_MUL:  state_d = S_MUL;
                    OP_IN:   state_d = S_WAIT_PRESS;
                    3'd7:    state_d = S_HALT;
                    default: state_d = S_EXEC;
                endcase
            end
            S_MUL:          if (mul_last) state_d = S_EXEC;
            S_WAIT_PRESS:   if (sw_go_s)  state_d = S_WAIT_RELEASE;
            S_WAIT_RELEASE: if (!sw_go_s) state_d = S_EXEC;
            S_HALT:         state_d = S_HALT;
            default:        state_d = S_EXEC;
        endcase
    end

    always_comb begin
        wr_en    = 1'b0;
        wr_dat   = '0;
        pc_d     = pc_q;
        led_d    = led_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        busy     = 1'b0;
        halted   = 1'b0;
        case (state_q)
            S_EXEC: begin
                case (op)
                    OP_LDI:  begin wr_en = 1'b1; wr_dat = imm;             pc_d = pc_inc; end
                    OP_ADD:  begin wr_en = 1'b1; wr_dat = rd_val + rs_val; pc_d = pc_inc; end
                    OP_ADDI: begin wr_en = 1'b1; wr_dat = rd_val + imm;    pc_d = pc_inc; end
                    OP_MUL: begin
                        mcand_d  = {{DW{1'b0}}, rd_val};
                        mplier_d = rs_val;
                        acc_d    = '0;
                        cnt_d    = '0;
                    end
                    OP_OUT:  begin led_d = rs_val; pc_d = pc_inc; end
                    OP_BNZ:  pc_d = (rd_val != '0) ? br_dst : pc_inc;
                    default: ;
                endcase
            end
            S_MUL: begin
                busy     = 1'b1;
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (mul_last) begin
                    wr_en  = 1'b1;
                    wr_dat = mul_res;
                    pc_d   = pc_inc;
                end
            end
            S_WAIT_PRESS: begin
                busy = 1'b1;
                if (sw_go_s) begin
                    wr_en  = 1'b1;
                    wr_dat = bus.sw_data;
                end
            end
            S_WAIT_RELEASE: begin
                busy = 1'b1;
                if (!sw_go_s) pc_d = pc_inc;
            end
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q     <= '0;
            led_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            pc_q     <= pc_d;
            led_q    <= led_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            sync1_q  <= bus.sw_go;
            sync2_q  <= sync1_q;
            if (wr_en) regs_q[rd] <= wr_dat;
        end
    end

    assign bus.pc     = pc_q;
    assign bus.led    = led_q;
    assign bus.busy   = busy;
    assign bus.halted = halted;
endmodule

// File: tb/tb_pico_mips_core.sv
// Scoreboard bench: an ISA-level model predicts LED changes and HALT (value, pc, cycle);
// a negedge monitor compares them against the core as they appear.
module tb_pico_mips_core;
    localparam int DW        = 8;
    localparam int NREG      = 8;
    localparam int PDEPTH    = 32;
    localparam int PW        = 5;
    localparam int IW        = 17;
    localparam int MAX_STEPS = 120;

    typedef struct {
        logic          kind;
        logic [DW-1:0] val;
        logic [PW-1:0] pc;
        int            cyc;
    } ev_t;

    typedef struct {
        logic [DW-1:0] val;
        logic [PW-1:0] pc;
    } press_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pico_mips_core_if #(.DW(DW), .NREG(NREG), .PDEPTH(PDEPTH)) bus ();
    pico_mips_core #(.DW(DW), .NREG(NREG), .PDEPTH(PDEPTH)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.master)
    );

    logic [IW-1:0] prog [PDEPTH];
    assign bus.instr = prog[bus.pc];

    ev_t           exp_q [$];
    press_t        press_q [$];
    logic [DW-1:0] in_vals [$];
    int            n_vec = 0;
    int            n_bad = 0;
    int            cyc;
    int            busy_cnt;
    logic [DW-1:0] prev_led;
    logic          prev_halt;

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic ev_check(logic kind, logic [DW-1:0] val);
        ev_t e;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_%s: val=%0d pc=%0d cyc=%0d, expected no event",
                     kind ? "halt" : "led", val, bus.pc, cyc);
            return;
        end
        e = exp_q.pop_front();
        if (e.kind !== kind || e.val !== val || e.pc !== bus.pc || (e.cyc >= 0 && e.cyc != cyc)) begin
            n_bad++;
            $display("FAIL event: got kind=%0d val=%0d pc=%0d cyc=%0d, expected kind=%0d val=%0d pc=%0d cyc=%0d",
                     kind, val, bus.pc, cyc, e.kind, e.val, e.pc, e.cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_led  = '0;
            prev_halt = 1'b0;
            busy_cnt  = 0;
        end else begin
            if (bus.busy) busy_cnt++;
            if (bus.led !== prev_led) ev_check(1'b0, bus.led);
            if (bus.halted && !prev_halt) ev_check(1'b1, '0);
            prev_led  = bus.led;
            prev_halt = bus.halted;
        end
    end

    function automatic logic [IW-1:0] enc(int op, int rd, int rs, int imm);
        return {3'(op), 3'(rd), 3'(rs), 8'(imm)};
    endfunction

    // Instruction-level model; returns the halt cycle, 0 if timing depends on the button, -1 if no halt.
    function automatic int model(bit push);
        int t, pc, led, ii, op, rd, rs, imm, p;
        int r [NREG];
        bit tk;
        logic [IW-1:0] w;
        ev_t e;
        press_t pr;
        t = 0; pc = 0; led = 0; ii = 0; tk = 1'b1;
        for (int i = 0; i < NREG; i++) r[i] = 0;
        for (int s = 0; s < MAX_STEPS; s++) begin
            w   = prog[pc];
            op  = int'(w[16:14]);
            rd  = int'(w[13:11]);
            rs  = int'(w[10:8]);
            imm = int'(w[7:0]);
            case (op)
                0: begin r[rd] = imm;                          t += 1; pc = (pc + 1) % PDEPTH; end
                1: begin r[rd] = (r[rd] + r[rs]) % (1 << DW);  t += 1; pc = (pc + 1) % PDEPTH; end
                2: begin r[rd] = (r[rd] + imm) % (1 << DW);    t += 1; pc = (pc + 1) % PDEPTH; end
                3: begin
                    p     = r[rd] * r[rs];
                    r[rd] = (imm % 2 == 1) ? p / (1 << DW) : p % (1 << DW);
                    t    += DW + 1;
                    pc    = (pc + 1) % PDEPTH;
                end
                4: begin
                    if (ii >= in_vals.size()) return -1;
                    if (push) begin
                        pr.val = in_vals[ii];
                        pr.pc  = PW'(pc);
                        press_q.push_back(pr);
                    end
                    r[rd] = int'(in_vals[ii]);
                    ii++;
                    tk = 1'b0;
                    pc = (pc + 1) % PDEPTH;
                end
                5: begin
                    t += 1;
                    pc = (pc + 1) % PDEPTH;
                    if (r[rs] != led) begin
                        led = r[rs];
                        if (push) begin
                            e.kind = 1'b0; e.val = DW'(led); e.pc = PW'(pc); e.cyc = tk ? t : -1;
                            exp_q.push_back(e);
                        end
                    end
                end
                6: begin
                    t += 1;
                    if (r[rd] != 0) begin
                        pc = imm % (1 << PW);
                        if (pc >= PDEPTH) pc = 0;
                    end else begin
                        pc = (pc + 1) % PDEPTH;
                    end
                end
                default: begin
                    t += 1;
                    if (push) begin
                        e.kind = 1'b1; e.val = '0; e.pc = PW'(pc); e.cyc = tk ? t : -1;
                        exp_q.push_back(e);
                    end
                    return tk ? t : 0;
                end
            endcase
        end
        return -1;
    endfunction

    task automatic clear_prog();
        for (int i = 0; i < PDEPTH; i++) prog[i] = enc(2, 0, 0, 0);
        in_vals.delete();
    endtask

    task automatic run_prog(string name);
        int t, budget, i;
        rst = 1'b1;
        exp_q.delete();
        press_q.delete();
        t = model(1'b1);
        budget = (t > 0) ? t + 20 : 3000;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        i = 0;
        while (!bus.halted && i < budget) begin
            @(negedge clk);
            i++;
        end
        check({name, "_halted"}, 32'(bus.halted), 1);
        repeat (4) @(negedge clk);
        check({name, "_events_left"}, exp_q.size(), 0);
    endtask

    task automatic gen_random();
        int k;
        clear_prog();
        for (int i = 0; i < PDEPTH; i++) begin
            k = $urandom_range(0, 99);
            if      (k < 18) prog[i] = enc(0, $urandom_range(0, 7), 0, $urandom_range(0, 255));
            else if (k < 32) prog[i] = enc(1, $urandom_range(0, 7), $urandom_range(0, 7), 0);
            else if (k < 46) prog[i] = enc(2, $urandom_range(0, 7), 0, $urandom_range(0, 255));
            else if (k < 60) prog[i] = enc(3, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 255));
            else if (k < 78) prog[i] = enc(5, 0, $urandom_range(0, 7), 0);
            else if (k < 92) prog[i] = enc(6, $urandom_range(0, 7), 0, $urandom_range(0, 255));
            else             prog[i] = enc(7, 0, 0, 0);
        end
    endtask

    // Button driver: one full press per queued IN, held long enough to expose re-triggering.
    initial begin
        bus.sw_go   = 1'b0;
        bus.sw_data = '0;
        forever begin
            press_t p;
            int w;
            @(negedge clk);
            if (press_q.size() > 0 && !rst) begin
                p = press_q[0];
                w = 0;
                while (!bus.busy && w < 400) begin
                    @(negedge clk);
                    w++;
                end
                check("press_wait_busy", 32'(bus.busy), 1);
                if (bus.busy) begin
                    repeat (3) @(negedge clk);
                    bus.sw_data = p.val;
                    bus.sw_go   = 1'b1;
                    repeat (20) @(negedge clk);
                    check("pc_stall_while_held", 32'(bus.pc), 32'(p.pc));
                    check("busy_while_held", 32'(bus.busy), 1);
                    bus.sw_go = 1'b0;
                    repeat (8) @(negedge clk);
                end
                if (press_q.size() > 0) void'(press_q.pop_front());
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1, "watchdog timeout");
    end

    initial begin
        int tries;
        clear_prog();
        repeat (2) @(negedge clk);
        check("reset_pc", 32'(bus.pc), 0);
        check("reset_busy", 32'(bus.busy), 0);

        clear_prog();
        prog[0] = enc(0, 1, 0, 200);
        prog[1] = enc(2, 1, 0, 100);
        prog[2] = enc(5, 0, 1, 0);
        prog[3] = enc(7, 0, 0, 0);
        run_prog("addi_wrap");
        check("addi_wrap_led", 32'(bus.led), 44);
        check("addi_wrap_pc", 32'(bus.pc), 3);

        #2 rst = 1'b1;
        #1;
        check("async_rst_pc", 32'(bus.pc), 0);
        check("async_rst_led", 32'(bus.led), 0);
        check("async_rst_busy", 32'(bus.busy), 0);
        check("async_rst_halted", 32'(bus.halted), 0);

        clear_prog();
        prog[0] = enc(0, 2, 0, 13);
        prog[1] = enc(0, 3, 0, 21);
        prog[2] = enc(3, 2, 3, 0);
        prog[3] = enc(5, 0, 2, 0);
        prog[4] = enc(0, 2, 0, 13);
        prog[5] = enc(3, 2, 3, 1);
        prog[6] = enc(5, 0, 2, 0);
        prog[7] = enc(7, 0, 0, 0);
        run_prog("mul_lo_hi");
        check("mul_busy_cycles", busy_cnt, 2 * DW);
        check("mul_hi_led", 32'(bus.led), 1);

        clear_prog();
        prog[0] = enc(4, 4, 0, 0);
        prog[1] = enc(4, 5, 0, 0);
        prog[2] = enc(5, 0, 4, 0);
        prog[3] = enc(5, 0, 5, 0);
        prog[4] = enc(7, 0, 0, 0);
        in_vals.push_back(8'hA5);
        in_vals.push_back(8'h3C);
        run_prog("in_press");

        clear_prog();
        prog[0] = enc(0, 5, 0, 3);
        prog[1] = enc(2, 5, 0, 255);
        prog[2] = enc(6, 5, 0, 1);
        prog[3] = enc(7, 0, 0, 0);
        run_prog("bnz_loop");
        check("bnz_loop_halted_pc", 32'(bus.pc), 3);

        clear_prog();
        prog[0] = enc(0, 2, 0, 13);
        prog[1] = enc(0, 3, 0, 21);
        prog[2] = enc(3, 2, 3, 0);
        prog[3] = enc(5, 0, 2, 0);
        prog[4] = enc(7, 0, 0, 0);
        rst = 1'b1;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        tries = 0;
        while (!bus.busy && tries < 20) begin
            @(negedge clk);
            tries++;
        end
        check("mul_entered", 32'(bus.busy), 1);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("mul_abort_busy", 32'(bus.busy), 0);
        check("mul_abort_pc", 32'(bus.pc), 2'd0);
        clear_prog();
        prog[0] = enc(2, 2, 0, 1);
        prog[1] = enc(5, 0, 2, 0);
        prog[2] = enc(7, 0, 0, 0);
        run_prog("after_abort");
        check("after_abort_led", 32'(bus.led), 1);

        clear_prog();
        prog[0] = enc(6, 2, 0, 3);
        prog[1] = enc(2, 2, 0, 1);
        prog[2] = enc(6, 2, 0, 4);
        prog[3] = enc(7, 0, 0, 0);
        prog[4] = enc(5, 0, 2, 0);
        run_prog("pc_wrap");

        for (int n = 0; n < 20; n++) begin
            tries = 0;
            do begin
                gen_random();
                tries++;
            end while (model(1'b0) < 0 && tries < 100);
            if (model(1'b0) < 0) prog[0] = enc(7, 0, 0, 0);
            run_prog("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
